// File: rtl/fragment_hazard_guard_pkg.sv
// Shared types and constants for the fragment hazard guard.
// Pixel layout, color field positions and statistics widths.
package fragment_hazard_guard_pkg;

   localparam int STALL_WIDTH    = 16;
   localparam int COLOR_CHANNELS = 4;

   // Channel order inside a packed RGBA pixel, alpha in the low bits
   localparam int FIELD_A = 0;
   localparam int FIELD_B = 1;
   localparam int FIELD_G = 2;
   localparam int FIELD_R = 3;

   function automatic int pixel_width(input int sub_pixel_width);
      return COLOR_CHANNELS * sub_pixel_width;
   endfunction

   function automatic int field_lsb(input int sub_pixel_width, input int field);
      return field * sub_pixel_width;
   endfunction

endpackage

// File: rtl/fragment_hazard_guard_hazard_window.sv
// Recent-issue history of framebuffer indices with a parallel compare
// against the fragment waiting at the input.
module fragment_hazard_guard_hazard_window
   import fragment_hazard_guard_pkg::*;
#(
   parameter int INDEX_WIDTH = 14,
   parameter int DEPTH       = 4
) (
   input  logic                   aclk,
   input  logic                   reset,
   input  logic                   push_valid,
   input  logic [INDEX_WIDTH-1:0] push_index,
   input  logic [INDEX_WIDTH-1:0] query_index,
   input  logic                   confEnable,
   output logic                   hit
);

   logic [DEPTH-1:0]       hist_valid;
   logic [INDEX_WIDTH-1:0] hist_index [DEPTH];
   logic                   match;

   // Shifts every cycle so bubbles age the window like real issues
   always_ff @(posedge aclk) begin
      if (reset) begin
         hist_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            hist_index[i] <= '0;
         end
      end else begin
         hist_valid[0] <= push_valid;
         hist_index[0] <= push_index;
         for (int i = 1; i < DEPTH; i++) begin
            hist_valid[i] <= hist_valid[i-1];
            hist_index[i] <= hist_index[i-1];
         end
      end
   end

   // The push slot is the output register, compared alongside the history
   always_comb begin
      match = push_valid && (push_index == query_index);
      for (int i = 0; i < DEPTH; i++) begin
         match = match || (hist_valid[i] && (hist_index[i] == query_index));
      end
      hit = confEnable && match;
   end

endmodule

// File: rtl/fragment_hazard_guard.sv
// Holds back fragments whose framebuffer index is still inside the
// read/modify/write window of the downstream per-fragment pipeline.
module fragment_hazard_guard
   import fragment_hazard_guard_pkg::*;
#(
   parameter  int FRAMEBUFFER_INDEX_WIDTH = 14,
   parameter  int SCREEN_POS_WIDTH        = 16,
   parameter  int SUB_PIXEL_WIDTH         = 8,
   parameter  int HAZARD_WINDOW           = 6,
   parameter  int INFLIGHT_WIDTH          = 4,
   localparam int PIXEL_WIDTH             = pixel_width(SUB_PIXEL_WIDTH)
) (
   input  logic                               aclk,
   input  logic                               reset,
   input  logic                               confEnable,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [PIXEL_WIDTH-1:0]             s_fragmentColor,
   input  logic [31:0]                        s_depth,
   input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_index,
   input  logic [SCREEN_POS_WIDTH-1:0]        s_screenPosX,
   input  logic [SCREEN_POS_WIDTH-1:0]        s_screenPosY,
   output logic                               m_valid,
   output logic [PIXEL_WIDTH-1:0]             m_fragmentColor,
   output logic [31:0]                        m_depth,
   output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index,
   output logic [SCREEN_POS_WIDTH-1:0]        m_screenPosX,
   output logic [SCREEN_POS_WIDTH-1:0]        m_screenPosY,
   input  logic                               fragmentProcessed,
   output logic                               idle,
   output logic [STALL_WIDTH-1:0]             stallCount
);

   // The accepting cycle is the first window slot and the output register
   // the second, so the history holds the remaining HAZARD_WINDOW-2.
   localparam int HIST_DEPTH = HAZARD_WINDOW - 2;

   logic                      hazard;
   logic                      accept;
   logic [INFLIGHT_WIDTH-1:0] in_flight;
   logic [INFLIGHT_WIDTH-1:0] in_flight_next;

   fragment_hazard_guard_hazard_window #(
      .INDEX_WIDTH (FRAMEBUFFER_INDEX_WIDTH),
      .DEPTH       (HIST_DEPTH)
   ) u_window (
      .aclk        (aclk),
      .reset       (reset),
      .push_valid  (m_valid),
      .push_index  (m_index),
      .query_index (s_index),
      .confEnable  (confEnable),
      .hit         (hazard)
   );

   assign s_ready = !reset && !hazard;
   assign accept  = s_valid && s_ready;

   always_comb begin
      in_flight_next = in_flight;
      unique case ({accept, fragmentProcessed})
         2'b10: if (in_flight != '1) in_flight_next = in_flight + 1'b1;
         2'b01: if (in_flight != '0) in_flight_next = in_flight - 1'b1;
         default: in_flight_next = in_flight;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         m_valid         <= 1'b0;
         m_fragmentColor <= '0;
         m_depth         <= '0;
         m_index         <= '0;
         m_screenPosX    <= '0;
         m_screenPosY    <= '0;
         in_flight       <= '0;
         idle            <= 1'b1;
         stallCount      <= '0;
      end else begin
         m_valid <= accept;
         if (accept) begin
            m_fragmentColor <= s_fragmentColor;
            m_depth         <= s_depth;
            m_index         <= s_index;
            m_screenPosX    <= s_screenPosX;
            m_screenPosY    <= s_screenPosY;
         end
         if (s_valid && !s_ready && (stallCount != '1)) begin
            stallCount <= stallCount + 1'b1;
         end
         in_flight <= in_flight_next;
         idle      <= (in_flight_next == '0) && !accept;
      end
   end

endmodule

// File: tb/tb_fragment_hazard_guard.sv
// Bench for fragment_hazard_guard: vector table of fragments with
// expected stall counts, scoreboard of issued payloads, corner sequences.
module tb_fragment_hazard_guard;

   logic        aclk = 1'b0;
   logic        reset;
   logic        confEnable;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_fragmentColor;
   logic [31:0] s_depth;
   logic [13:0] s_index;
   logic [15:0] s_screenPosX;
   logic [15:0] s_screenPosY;
   logic        m_valid;
   logic [31:0] m_fragmentColor;
   logic [31:0] m_depth;
   logic [13:0] m_index;
   logic [15:0] m_screenPosX;
   logic [15:0] m_screenPosY;
   logic        fragmentProcessed;
   logic        idle;
   logic [15:0] stallCount;

   fragment_hazard_guard dut (
      .aclk              (aclk),
      .reset             (reset),
      .confEnable        (confEnable),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .s_fragmentColor   (s_fragmentColor),
      .s_depth           (s_depth),
      .s_index           (s_index),
      .s_screenPosX      (s_screenPosX),
      .s_screenPosY      (s_screenPosY),
      .m_valid           (m_valid),
      .m_fragmentColor   (m_fragmentColor),
      .m_depth           (m_depth),
      .m_index           (m_index),
      .m_screenPosX      (m_screenPosX),
      .m_screenPosY      (m_screenPosY),
      .fragmentProcessed (fragmentProcessed),
      .idle              (idle),
      .stallCount        (stallCount)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [13:0] idx;
      logic        conf;
      int          gap;
      int          stalls;
   } vec_t;

   typedef struct {
      logic [31:0] color;
      logic [31:0] depth;
      logic [13:0] idx;
      logic [15:0] x;
      logic [15:0] y;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   exp_stall = 0;
   vec_t vecs[$];

   always @(posedge aclk) cyc <= cyc + 1;

   // Scoreboard: every cycle m_valid must match the expected issue slot
   always @(posedge aclk) begin
      #1;
      if (reset) begin
         q.delete();
      end else begin
         checks++;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            if (!m_valid || m_index !== q[0].idx ||
                m_fragmentColor !== q[0].color || m_depth !== q[0].depth ||
                m_screenPosX !== q[0].x || m_screenPosY !== q[0].y) begin
               errors++;
               $display("FAIL issue cyc=%0d: got v=%b idx=%0d col=%h dep=%h x=%h y=%h, want idx=%0d col=%h dep=%h x=%h y=%h",
                        cyc, m_valid, m_index, m_fragmentColor, m_depth,
                        m_screenPosX, m_screenPosY, q[0].idx, q[0].color,
                        q[0].depth, q[0].x, q[0].y);
            end
            void'(q.pop_front());
         end else if (m_valid) begin
            errors++;
            $display("FAIL unexpected m_valid cyc=%0d idx=%0d, want no issue",
                     cyc, m_index);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic cyc_drive(input logic v, input logic [13:0] idx,
                            input logic conf, input logic ret,
                            output logic acc);
      exp_t e;
      @(negedge aclk);
      s_valid           = v;
      s_index           = idx;
      confEnable        = conf;
      fragmentProcessed = ret;
      s_fragmentColor   = $urandom;
      s_depth           = $urandom;
      s_screenPosX      = 16'($urandom);
      s_screenPosY      = 16'($urandom);
      #1;
      acc     = v && s_ready;
      e.color = s_fragmentColor;
      e.depth = s_depth;
      e.idx   = idx;
      e.x     = s_screenPosX;
      e.y     = s_screenPosY;
      e.cyc   = cyc + 1;
      @(posedge aclk);
      if (acc) q.push_back(e);
   endtask

   task automatic send(input vec_t r);
      logic acc;
      int   n;
      for (int i = 0; i < r.gap; i++) cyc_drive(1'b0, r.idx, r.conf, 1'b0, acc);
      n   = 0;
      acc = 1'b0;
      while (!acc && n <= 20) begin
         cyc_drive(1'b1, r.idx, r.conf, 1'b0, acc);
         if (!acc) n++;
      end
      exp_stall += r.stalls;
      checks++;
      if (!acc || n != r.stalls) begin
         errors++;
         $display("FAIL stalls idx=%0d: got %0d (accepted=%b), want %0d",
                  r.idx, n, acc, r.stalls);
      end
      #1;
      check("stallCount", 32'(stallCount), 32'(exp_stall));
   endtask

   task automatic idle_step(input logic v, input logic [13:0] idx,
                            input logic ret, input logic want, input string name);
      logic acc;
      cyc_drive(v, idx, 1'b1, ret, acc);
      #1;
      check(name, 32'(idle), 32'(want));
   endtask

   task automatic add(input logic [13:0] idx, input logic conf,
                      input int gap, input int stalls);
      vec_t r;
      r.idx = idx; r.conf = conf; r.gap = gap; r.stalls = stalls;
      vecs.push_back(r);
   endtask

   initial begin
      logic acc;
      vec_t r;
      reset             = 1'b1;
      confEnable        = 1'b1;
      s_valid           = 1'b0;
      s_index           = '0;
      s_fragmentColor   = '0;
      s_depth           = '0;
      s_screenPosX      = '0;
      s_screenPosY      = '0;
      fragmentProcessed = 1'b0;

      repeat (2) @(posedge aclk);
      #1;
      check("reset m_valid", 32'(m_valid), 0);
      check("reset m_index", 32'(m_index), 0);
      check("reset m_depth", m_depth, 0);
      check("reset m_color", m_fragmentColor, 0);
      check("reset stallCount", 32'(stallCount), 0);
      check("reset idle", 32'(idle), 1);
      check("reset s_ready", 32'(s_ready), 0);
      @(negedge aclk);
      reset = 1'b0;

      // In-flight tracking: one retire coincides with an issue, one is extra
      idle_step(1'b1, 14'd100, 1'b0, 1'b0, "idle after A");
      idle_step(1'b1, 14'd101, 1'b0, 1'b0, "idle after B");
      idle_step(1'b1, 14'd102, 1'b1, 1'b0, "idle after C+retire");
      idle_step(1'b0, 14'd0,   1'b1, 1'b0, "idle after retire 2");
      idle_step(1'b0, 14'd0,   1'b1, 1'b1, "idle after retire 3");
      idle_step(1'b0, 14'd0,   1'b1, 1'b1, "idle extra retire");
      idle_step(1'b1, 14'd103, 1'b0, 1'b0, "idle after D");
      idle_step(1'b0, 14'd0,   1'b1, 1'b1, "idle after D retire");

      add(14'd0, 1'b1, 6, 0);
      add(14'd1, 1'b1, 0, 0);
      add(14'd2, 1'b1, 0, 0);
      add(14'd3, 1'b1, 0, 0);
      add(14'd7, 1'b1, 0, 0);
      add(14'd7, 1'b1, 0, 5);
      add(14'd7, 1'b1, 6, 0);
      add(14'd7, 1'b1, 0, 5);
      add(14'd9, 1'b1, 0, 0);
      add(14'd7, 1'b0, 6, 0);
      add(14'd7, 1'b0, 0, 0);
      add(14'd7, 1'b0, 0, 0);
      add(14'd7, 1'b1, 0, 5);
      add(14'd8, 1'b1, 6, 0);
      add(14'd20, 1'b1, 0, 0);
      add(14'd8, 1'b1, 0, 4);
      foreach (vecs[i]) begin
         r = vecs[i];
         send(r);
      end

      // Reset with index 5 sitting in the output register
      r.idx = 14'd5; r.conf = 1'b1; r.gap = 2; r.stalls = 0;
      send(r);
      @(negedge aclk);
      s_valid           = 1'b0;
      fragmentProcessed = 1'b0;
      reset             = 1'b1;
      #1;
      check("s_ready in reset", 32'(s_ready), 0);
      @(posedge aclk);
      #1;
      exp_stall = 0;
      check("mid reset m_valid", 32'(m_valid), 0);
      check("mid reset m_index", 32'(m_index), 0);
      check("mid reset m_color", m_fragmentColor, 0);
      check("mid reset idle", 32'(idle), 1);
      check("mid reset stallCount", 32'(stallCount), 0);
      @(negedge aclk);
      reset = 1'b0;
      idle_step(1'b0, 14'd0, 1'b1, 1'b1, "idle late retire");
      r.gap = 0;
      send(r);
      idle_step(1'b0, 14'd0, 1'b1, 1'b1, "idle after 5 retire");

      repeat (3) cyc_drive(1'b0, 14'd0, 1'b1, 1'b0, acc);
      #1;
      check("scoreboard drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
